// File: rtl/mult_stim_gen_pkg.sv
// mult_stim_pkg: shared types, constants and helpers for the multiplier stimulus generator.
package mult_stim_pkg;

    typedef enum logic [2:0] {IDLE, GEN_A, GEN_B, SEND, WAIT_RES, DONE} state_t;

    typedef enum logic [1:0] {MODE_RND, MODE_CORNER, MODE_NOPERR, MODE_RSVD} mode_t;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    localparam logic [1:0] C_MIN  = 2'd0;
    localparam logic [1:0] C_MAX  = 2'd1;
    localparam logic [1:0] C_ZERO = 2'd2;
    localparam logic [1:0] C_ONES = 2'd3;

    function automatic logic parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/mult_stim_gen_if.sv
// mult_stim_gen_if: operand/result handshake between the stimulus generator and the multiplier.
interface mult_stim_gen_if #(parameter int DATA_W = 16);
    logic              req;
    logic              ack;
    logic [DATA_W-1:0] arg_a;
    logic              arg_a_parity;
    logic [DATA_W-1:0] arg_b;
    logic              arg_b_parity;
    logic [1:0]        perr_inj;
    logic              res_valid;

    modport master (
        output req, arg_a, arg_a_parity, arg_b, arg_b_parity, perr_inj,
        input  ack, res_valid
    );

    modport slave (
        input  req, arg_a, arg_a_parity, arg_b, arg_b_parity, perr_inj,
        output ack, res_valid
    );
endinterface

// File: rtl/mult_stim_lfsr.sv
// mult_stim_lfsr: 32-bit shift-right Galois LFSR, stepping once per cycle while adv is high.
module mult_stim_lfsr
    import mult_stim_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    output logic [31:0] value
);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            value <= SEED;
        else if (adv)
            value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : 32'h0);

endmodule

// File: rtl/mult_stim_gen.sv
// mult_stim_gen: issues parity-protected operand pairs (random, corner, injected errors) over req/ack
// and waits for each result or a timeout before the next vector.
module mult_stim_gen
    import mult_stim_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter int          N_VECTORS = 1000,
    parameter logic [31:0] SEED      = 32'h1,
    parameter int          TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           mode,
    mult_stim_gen_if.master      bus,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          vec_cnt,
    output logic [15:0]          timeout_cnt
);

    localparam logic [DATA_W-1:0] V_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] V_MAX = ~V_MIN;

    state_t            state;
    logic [31:0]       lfsr;
    logic [31:0]       wcnt;
    logic [DATA_W-1:0] rnd_val, cor_val, val;
    logic [1:0]        ci;
    logic              inj, par, last, unused_lfsr;

    assign unused_lfsr = ^lfsr;
    assign last        = vec_cnt + 32'd1 == 32'(N_VECTORS);

    mult_stim_lfsr #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (state == GEN_A || state == GEN_B),
        .value (lfsr)
    );

    // Corner sweep: A walks the table on k[3:2], B on k[1:0].
    always_comb begin
        ci      = (state == GEN_A) ? vec_cnt[3:2] : vec_cnt[1:0];
        cor_val = (ci == C_MIN) ? V_MIN : (ci == C_MAX) ? V_MAX : (ci == C_ZERO) ? '0 : '1;
        rnd_val = (lfsr[31:29] == 3'b000) ? V_MIN :
                  (lfsr[31:29] == 3'b111) ? V_MAX :
                  (lfsr[31:29] == 3'b001) ? '0 : lfsr[DATA_W-1:0];
        val     = (mode == MODE_CORNER) ? cor_val : rnd_val;
        inj     = (mode != MODE_CORNER) && (mode != MODE_NOPERR) && (lfsr[28:27] == 2'b11);
        par     = parity(32'(val)) ^ inj;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state            <= IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            vec_cnt          <= '0;
            timeout_cnt      <= '0;
            wcnt             <= '0;
            bus.req          <= 1'b0;
            bus.arg_a        <= '0;
            bus.arg_a_parity <= 1'b0;
            bus.arg_b        <= '0;
            bus.arg_b_parity <= 1'b0;
            bus.perr_inj     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE:
                    if (start) begin
                        vec_cnt     <= '0;
                        timeout_cnt <= '0;
                        busy        <= 1'b1;
                        done        <= N_VECTORS == 0;
                        state       <= (N_VECTORS == 0) ? DONE : GEN_A;
                    end
                GEN_A: begin
                    bus.arg_a        <= val;
                    bus.arg_a_parity <= par;
                    bus.perr_inj[0]  <= inj;
                    state            <= GEN_B;
                end
                GEN_B: begin
                    bus.arg_b        <= val;
                    bus.arg_b_parity <= par;
                    bus.perr_inj[1]  <= inj;
                    bus.req          <= 1'b1;
                    state            <= SEND;
                end
                SEND:
                    if (bus.ack) begin
                        bus.req <= 1'b0;
                        wcnt    <= '0;
                        state   <= WAIT_RES;
                    end
                // A result in the timeout cycle wins over the timeout.
                WAIT_RES:
                    if (bus.res_valid || wcnt + 32'd1 >= 32'(TIMEOUT)) begin
                        vec_cnt     <= vec_cnt + 32'd1;
                        timeout_cnt <= bus.res_valid ? timeout_cnt : timeout_cnt + 16'(timeout_cnt != 16'hFFFF);
                        done        <= last;
                        state       <= last ? DONE : GEN_A;
                    end else
                        wcnt <= wcnt + 32'd1;
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end

endmodule

// File: tb/tb_mult_stim_gen.sv
// tb_mult_stim_gen: randomized responder with a queue scoreboard fed by a spec-level LFSR/operand model.
module tb_mult_stim_gen;

    localparam int          W    = 16;
    localparam int          NV   = 16;
    localparam int          TO   = 8;
    localparam logic [31:0] SEED = 32'h1;

    typedef struct packed {
        logic [W-1:0] a;
        logic         ap;
        logic [W-1:0] b;
        logic         bp;
        logic [1:0]   pe;
    } vec_t;

    logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, start0 = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        busy, done, busy0, done0;
    logic [31:0] vec_cnt, vec0;
    logic [15:0] to_cnt, to0;

    mult_stim_gen_if #(.DATA_W(W)) bus ();
    mult_stim_gen_if #(.DATA_W(W)) zbus ();

    mult_stim_gen #(.DATA_W(W), .N_VECTORS(NV), .SEED(SEED), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .bus(bus),
        .busy(busy), .done(done), .vec_cnt(vec_cnt), .timeout_cnt(to_cnt)
    );

    mult_stim_gen #(.DATA_W(W), .N_VECTORS(0), .SEED(SEED), .TIMEOUT(TO)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mode(2'b00), .bus(zbus),
        .busy(busy0), .done(done0), .vec_cnt(vec0), .timeout_cnt(to0)
    );

    always #5 clk = ~clk;

    int   passed = 0, total = 0;
    vec_t exp_q[$];
    logic [31:0] m_lfsr = SEED;
    int   ack_delay = 0, res_delay = 0, ack_wait = 0, res_wait = 0;
    bit   res_en = 1, gap_chk = 0, stat_en = 0, pending = 0;
    int   cyc = 0, last_xfer = -1, xfers = 0, done_pulses = 0;
    int   ops = 0, perr_ops = 0, min_ops = 0, max_ops = 0, zero_ops = 0;
    bit   zreq_seen = 0, perr_any = 0, hold_v = 0;
    vec_t seen[16];
    vec_t held, cur, ev, first00;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    function automatic void model_op(input logic [31:0] l, input logic [1:0] m, input int k,
                                     output logic [W-1:0] v, output logic p, output logic e);
        logic [W-1:0] tbl [4];
        tbl = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
        if (m == 2'b01) begin
            v = tbl[k];
            e = 1'b0;
        end else begin
            case (l[31:29])
                3'd0:    v = 16'h8000;
                3'd7:    v = 16'h7FFF;
                3'd1:    v = 16'h0000;
                default: v = l[W-1:0];
            endcase
            e = (m != 2'b10) && (l[28:27] == 2'b11);
        end
        p = (^v) ^ e;
    endfunction

    task automatic push_run(input logic [1:0] m);
        logic [W-1:0] va, vb;
        logic         pa, pb, ea, eb;
        for (int i = 0; i < NV; i++) begin
            model_op(m_lfsr, m, (i % 16) / 4, va, pa, ea);
            m_lfsr = step(m_lfsr);
            model_op(m_lfsr, m, i % 4, vb, pb, eb);
            m_lfsr = step(m_lfsr);
            exp_q.push_back({va, pa, vb, pb, eb, ea});
        end
    endtask

    // Responder: ack after ack_delay cycles of req, result pulse res_delay cycles after the transfer.
    initial begin
        bus.ack = 1'b0;  bus.res_valid = 1'b0;
        zbus.ack = 1'b0; zbus.res_valid = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.res_valid = 1'b0;
            if (!rst_n) begin
                bus.ack = 1'b0; pending = 0; ack_wait = 0;
            end else if (bus.ack) begin
                bus.ack = 1'b0; pending = 1; res_wait = 0;
            end else if (bus.req) begin
                if (ack_wait >= ack_delay) begin bus.ack = 1'b1; ack_wait = 0; end
                else ack_wait++;
            end else if (pending && res_en) begin
                if (res_wait >= res_delay) begin bus.res_valid = 1'b1; pending = 0; end
                else res_wait++;
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (zbus.req) zreq_seen = 1;
        cur = {bus.arg_a, bus.arg_a_parity, bus.arg_b, bus.arg_b_parity, bus.perr_inj};
        if (!rst_n) hold_v = 0;
        else begin
            if (done) done_pulses++;
            if (bus.req && bus.ack) begin
                if (hold_v) chk(cur == held, "hold_stable", cur, held);
                hold_v = 0;
                if (exp_q.size() == 0) chk(1'b0, "unexpected_xfer", cur, 0);
                else begin
                    ev = exp_q.pop_front();
                    chk(cur == ev, "vector", cur, ev);
                end
                if (xfers < 16) seen[xfers] = cur;
                xfers++;
                if (gap_chk && last_xfer >= 0) chk(cyc - last_xfer == 11, "timeout_gap", cyc - last_xfer, 11);
                last_xfer = cyc;
                if (cur.pe != 2'b00) perr_any = 1;
                if (stat_en) begin
                    ops      += 2;
                    perr_ops += int'(cur.pe[0]) + int'(cur.pe[1]);
                    min_ops  += int'(cur.a == 16'h8000) + int'(cur.b == 16'h8000);
                    max_ops  += int'(cur.a == 16'h7FFF) + int'(cur.b == 16'h7FFF);
                    zero_ops += int'(cur.a == 16'h0000) + int'(cur.b == 16'h0000);
                end
            end else if (bus.req) begin
                if (hold_v) chk(cur == held, "hold_stable", cur, held);
                else begin held = cur; hold_v = 1; end
            end else hold_v = 0;
        end
    end

    task automatic run(input logic [1:0] m, input int ad, input int rd, input bit ren,
                       input bit gapc, input bit dbl, input int exp_to);
        bit fin = 0;
        mode = m; ack_delay = ad; res_delay = rd; res_en = ren; gap_chk = gapc;
        last_xfer = -1; xfers = 0; done_pulses = 0;
        push_run(m);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clk);
            if (dbl && c == 10) start = 1'b1;
            if (dbl && c == 11) start = 1'b0;
            if (done) fin = 1;
        end
        chk(fin, "run_done", fin, 1);
        chk(vec_cnt == NV, "vec_cnt", vec_cnt, NV);
        chk(to_cnt == exp_to, "timeout_cnt", to_cnt, exp_to);
        chk(busy == 1'b1, "busy_in_done", busy, 1);
        @(negedge clk);
        chk({done, busy} == 2'b00, "idle_after_done", {done, busy}, 0);
        chk(done_pulses == 1, "done_pulses", done_pulses, 1);
        chk(xfers == NV, "transfers", xfers, NV);
        chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
        exp_q.delete();
        gap_chk = 0;
    endtask

    initial begin
        int  lat;
        bit  got_req;
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk(bus.req == 1'b0, "rst_req", bus.req, 0);
        chk({busy, done} == 2'b00, "rst_busy_done", {busy, done}, 0);
        chk(vec_cnt == 0 && to_cnt == 0, "rst_counters", {vec_cnt, to_cnt}, 0);
        chk(cur == '0, "rst_operands", cur, 0);
        @(negedge clk); rst_n = 1'b1;

        run(2'b00, 0, 0, 1, 0, 0, 0);
        first00 = seen[0];

        run(2'b01, 1, 1, 1, 0, 0, 0);
        chk(seen[0]  == {16'h8000, 1'b1, 16'h8000, 1'b1, 2'b00}, "corner_v0",  seen[0],  {16'h8000, 1'b1, 16'h8000, 1'b1, 2'b00});
        chk(seen[6]  == {16'h7FFF, 1'b1, 16'h0000, 1'b0, 2'b00}, "corner_v6",  seen[6],  {16'h7FFF, 1'b1, 16'h0000, 1'b0, 2'b00});
        chk(seen[15] == {16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 2'b00}, "corner_v15", seen[15], {16'hFFFF, 1'b0, 16'hFFFF, 1'b0, 2'b00});

        perr_any = 0;
        for (int r = 0; r < 4; r++) run(2'b10, $urandom_range(0, 3), $urandom_range(0, 3), 1, 0, r == 1, 0);
        chk(perr_any == 0, "noperr_mode", perr_any, 0);

        stat_en = 1;
        for (int r = 0; r < 60; r++)
            run((r % 4 == 3) ? 2'b11 : 2'b00, $urandom_range(0, 3), $urandom_range(0, 3), 1, 0, 0, 0);
        stat_en = 0;
        chk(perr_ops * 100 >= 20 * ops && perr_ops * 100 <= 30 * ops, "perr_rate", perr_ops, ops);
        chk(min_ops * 1000 >= 75 * ops && min_ops * 1000 <= 175 * ops, "min_rate", min_ops, ops);
        chk(max_ops * 1000 >= 75 * ops && max_ops * 1000 <= 175 * ops, "max_rate", max_ops, ops);
        chk(zero_ops * 1000 >= 75 * ops && zero_ops * 1000 <= 175 * ops, "zero_rate", zero_ops, ops);

        run(2'b00, 5, 2, 1, 0, 0, 0);
        run(2'b00, 0, 0, 0, 1, 0, NV);
        run(2'b00, 0, 6, 1, 0, 0, 0);
        run(2'b00, 0, 7, 1, 0, 0, NV);

        // Abort a run while req is held, then check a fresh run repeats the first vector.
        mode = 2'b00; ack_delay = 5; res_en = 1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0; got_req = 0;
        for (int c = 1; c <= 10 && !got_req; c++) begin
            @(negedge clk);
            if (bus.req) begin got_req = 1; lat = c; end
        end
        chk(lat == 3, "req_latency", lat, 3);
        #2 rst_n = 1'b0;
        #1;
        chk({bus.req, busy} == 2'b00, "async_rst", {bus.req, busy}, 0);
        m_lfsr = SEED;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk(vec_cnt == 0 && to_cnt == 0, "post_rst_counters", {vec_cnt, to_cnt}, 0);
        run(2'b00, 0, 1, 1, 0, 0, 0);
        chk(seen[0] == first00, "replay_first_vec", seen[0], first00);

        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
        @(negedge clk);
        chk({done0, busy0} == 2'b11, "n0_done", {done0, busy0}, 2'b11);
        @(negedge clk);
        chk({done0, busy0} == 2'b00, "n0_idle", {done0, busy0}, 0);
        chk(vec0 == 0, "n0_vec_cnt", vec0, 0);
        chk(zreq_seen == 0, "n0_no_req", zreq_seen, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
